fp13_acumulador: RTL and testbench

//   Sequential accumulator for 13-bit floats (1 sign | 4 exp, bias 7 | 8 mantissa, hidden 1).

---
 rtl/fp13_acumulador.sv | 178 +++++++++++++++++
 tb/tb_fp13_acumulador.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp13_acumulador.sv
// Running-sum accumulator for fp13 values (1|4 exp bias 7|8 man), align/add/normalize FSM.
// Define FP13_ACC_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp13_acumulador #(
    parameter int NB_FLOAT = 13,
    parameter int NB_EXP   = 4,
    parameter int NB_MAN   = 8,
    parameter int NB_GUARD = 3
) (
    input  logic                clock,
    input  logic                i_reset_n,
    input  logic                i_valid,
    input  logic [NB_FLOAT-1:0] i_flotante,
    input  logic                i_clear,
    output logic                o_ready,
    output logic                o_valid,
    output logic [NB_FLOAT-1:0] o_acumulado,
    output logic                o_overflow
);
    localparam int NB_EXT = NB_MAN + 1 + NB_GUARD;
    localparam int NB_SUM = NB_EXT + 1;
`ifdef FP13_ACC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;
    state_t state_reg, state_next;
    logic   accept, clear_idle;

    logic [NB_FLOAT-1:0] acc_reg, op_reg;
    logic                ovf_reg, valid_reg;
    logic [NB_EXT-1:0]   big_ext_reg, sml_ext_reg;
    logic [NB_EXP-1:0]   exp_reg;
    logic                sign_reg, sub_reg;
    logic [NB_SUM-1:0]   sum_reg;

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) state_reg <= S_IDLE;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (i_valid) state_next = S_ALIGN;
            S_ALIGN: state_next = S_ADD;
            S_ADD:   state_next = S_NORM;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state_reg == S_IDLE);
        accept     = o_ready && i_valid;
        clear_idle = o_ready && i_clear;
    end

    // Operand 0 is the accumulator, operand 1 the latched input; exp 0 flushes to zero.
    logic [NB_FLOAT-1:0] opnd    [2];
    logic [NB_EXP-1:0]   u_exp   [2];
    logic [NB_EXT-1:0]   u_ext   [2];
    logic                u_sign  [2];
    assign opnd[0] = acc_reg;
    assign opnd[1] = op_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign u_sign[gi] = opnd[gi][NB_FLOAT-1];
            assign u_exp[gi]  = opnd[gi][NB_FLOAT-2:NB_MAN];
            assign u_ext[gi]  = (u_exp[gi] == '0) ? '0
                              : {1'b1, opnd[gi][NB_MAN-1:0], {NB_GUARD{1'b0}}};
        end
    endgenerate

    logic              a_big;
    logic [NB_EXT-1:0] big_ext, sml_ext, lost_mask, aligned;
    logic [NB_EXP-1:0] big_exp, sml_exp, diff;

    always_comb begin
        a_big     = {u_exp[0], u_ext[0]} >= {u_exp[1], u_ext[1]};
        big_ext   = a_big ? u_ext[0] : u_ext[1];
        sml_ext   = a_big ? u_ext[1] : u_ext[0];
        big_exp   = a_big ? u_exp[0] : u_exp[1];
        sml_exp   = a_big ? u_exp[1] : u_exp[0];
        diff      = big_exp - sml_exp;
        lost_mask = (NB_EXT'(1) << diff) - NB_EXT'(1);
        if (diff > 4'd11)
            aligned = {{(NB_EXT-1){1'b0}}, |sml_ext};
        else
            aligned = (sml_ext >> diff) | {{(NB_EXT-1){1'b0}}, |(sml_ext & lost_mask)};
    end

    logic [3:0]          lshift;
    logic [NB_EXT-1:0]   norm_ext;
    logic                norm_sticky, round_up;
    logic [6:0]          exp_s, exp_f;
    logic [NB_MAN-1:0]   man_t;
    logic [NB_MAN:0]     man_r;
    logic [NB_FLOAT-1:0] norm_res;
    logic                norm_ovf;

    always_comb begin
        lshift = '0;
        for (int i = 0; i < NB_EXT; i++)
            if (sum_reg[i]) lshift = 4'(NB_EXT - 1 - i);
        if (sum_reg[NB_SUM-1]) begin
            norm_ext    = sum_reg[NB_SUM-1:1];
            norm_sticky = sum_reg[0];
            exp_s       = {3'b000, exp_reg} + 7'd1;
        end else begin
            norm_ext    = sum_reg[NB_EXT-1:0] << lshift;
            norm_sticky = 1'b0;
            exp_s       = {3'b000, exp_reg} - {3'b000, lshift};
        end
        man_t    = norm_ext[NB_EXT-2:NB_GUARD];
        round_up = ROUND_EN & norm_ext[2] & (norm_ext[1] | norm_ext[0] | norm_sticky | man_t[0]);
        man_r    = {1'b0, man_t} + {{NB_MAN{1'b0}}, round_up};
        exp_f    = exp_s + {6'b0, man_r[NB_MAN]};
        norm_ovf = 1'b0;
        // exp_f is two's complement: bit 6 set means the exponent underflowed.
        if (sum_reg == '0 || exp_f[6] || exp_f == 7'd0) begin
            norm_res = '0;
        end else if (exp_f > 7'd15) begin
            norm_res = {sign_reg, {NB_EXP{1'b1}}, {NB_MAN{1'b1}}};
            norm_ovf = 1'b1;
        end else begin
            norm_res = {sign_reg, exp_f[NB_EXP-1:0], man_r[NB_MAN-1:0]};
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_reg     <= '0;
            op_reg      <= '0;
            ovf_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            big_ext_reg <= '0;
            sml_ext_reg <= '0;
            exp_reg     <= '0;
            sign_reg    <= 1'b0;
            sub_reg     <= 1'b0;
            sum_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) op_reg <= i_flotante;
                    if (clear_idle) begin
                        acc_reg <= '0;
                        ovf_reg <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    big_ext_reg <= big_ext;
                    sml_ext_reg <= aligned;
                    exp_reg     <= big_exp;
                    sign_reg    <= a_big ? u_sign[0] : u_sign[1];
                    sub_reg     <= u_sign[0] ^ u_sign[1];
                end
                S_ADD: begin
                    sum_reg <= sub_reg ? ({1'b0, big_ext_reg} - {1'b0, sml_ext_reg})
                                       : ({1'b0, big_ext_reg} + {1'b0, sml_ext_reg});
                end
                default: begin
                    acc_reg   <= norm_res;
                    valid_reg <= 1'b1;
                    if (norm_ovf) ovf_reg <= 1'b1;
                end
            endcase
        end
    end

    assign o_valid     = valid_reg;
    assign o_acumulado = acc_reg;
    assign o_overflow  = ovf_reg;
endmodule

// File: tb/tb_fp13_acumulador.sv
// Bench for fp13_acumulador: directed cases plus random operands against an exact-integer model.
module tb_fp13_acumulador;
`ifdef FP13_ACC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        i_reset_n, i_valid, i_clear;
    logic [12:0] i_flotante;
    logic        o_ready, o_valid, o_overflow;
    logic [12:0] o_acumulado;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] model_acc;
    logic        model_ovf;

    always #5 clock = ~clock;

    fp13_acumulador dut (
        .clock      (clock),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .i_flotante (i_flotante),
        .i_clear    (i_clear),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_acumulado(o_acumulado),
        .o_overflow (o_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value in units of the smallest mantissa LSB (exponent 1); exp field 0 is zero.
    function automatic longint to_int(input logic [12:0] f);
        longint mag;
        if (f[11:8] == 4'd0) return 0;
        mag = longint'({1'b1, f[7:0]}) << (int'(f[11:8]) - 1);
        return f[12] ? -mag : mag;
    endfunction

    // Returns {overflow, result}: exact sum, then truncate or round-nearest-even to fp13.
    function automatic logic [13:0] ref_add(input logic [12:0] a, input logic [12:0] b);
        longint s, m, q, rem, half;
        int     p, sh, e;
        logic   sg;
        s = to_int(a) + to_int(b);
        if (s == 0) return 14'd0;
        sg = (s < 0);
        m  = sg ? -s : s;
        p  = 0;
        for (int i = 0; i < 40; i++)
            if (((m >> i) & 64'sd1) != 0) p = i;
        if (p < 8) return 14'd0;
        sh  = p - 8;
        q   = m >> sh;
        rem = m - (q << sh);
        e   = p - 7;
        if (ROUND_EN && sh > 0) begin
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == 512) begin
                q = 256;
                e++;
            end
        end
        if (e > 15) return {1'b1, sg, 12'hFFF};
        return {1'b0, sg, 4'(e), 8'(q)};
    endfunction

    task automatic run_op(input logic [12:0] x, input logic clr);
        logic [13:0] r;
        r         = ref_add(clr ? 13'd0 : model_acc, x);
        model_acc = r[12:0];
        model_ovf = (clr ? 1'b0 : model_ovf) | r[13];
        @(negedge clock);
        check("ready_idle", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_flotante = x; i_clear = clr;
        @(negedge clock);
        // Junk requests while busy must be ignored.
        i_valid = 1'b1; i_flotante = 13'($urandom); i_clear = 1'($urandom);
        for (int k = 0; k < 3; k++) begin
            check("busy_ready", 32'(o_ready), 32'd0);
            check("busy_valid", 32'(o_valid), 32'd0);
            if (k < 2) @(negedge clock);
        end
        i_valid = 1'b0; i_clear = 1'b0;
        @(negedge clock);
        check("done_valid", 32'(o_valid), 32'd1);
        check("done_acc", 32'(o_acumulado), 32'(model_acc));
        check("done_ovf", 32'(o_overflow), 32'(model_ovf));
        $display("op in=%b clr=%0d acc=%b ovf=%0d", x, clr, o_acumulado, o_overflow);
    endtask

    task automatic do_clear();
        @(negedge clock);
        i_valid = 1'b0; i_clear = 1'b1;
        @(negedge clock);
        i_clear   = 1'b0;
        model_acc = 13'd0;
        model_ovf = 1'b0;
        check("clear_acc", 32'(o_acumulado), 32'd0);
        check("clear_ovf", 32'(o_overflow), 32'd0);
        check("clear_valid", 32'(o_valid), 32'd0);
        $display("clear acc=%b ovf=%0d", o_acumulado, o_overflow);
    endtask

    initial begin
        i_reset_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_flotante = 13'd0;
        model_acc = 13'd0; model_ovf = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_acc", 32'(o_acumulado), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        i_reset_n = 1'b1;

        do_clear();
        run_op(13'b0_1100_00011101, 1'b0);
        check("t2_const", 32'(o_acumulado), 32'(13'b0_1100_00011101));
        run_op(13'b1_1011_00101011, 1'b0);
        check("t3_const", 32'(o_acumulado), 32'(13'b0_1011_00001111));
        run_op(13'b1_1011_00001111, 1'b0);
        check("t3_cancel", 32'(o_acumulado), 32'd0);

        do_clear();
        run_op(13'b0_1111_11111111, 1'b0);
        run_op(13'b0_1111_11111111, 1'b0);
        check("t4_sat", 32'(o_acumulado), 32'(13'b0_1111_11111111));
        check("t4_ovf", 32'(o_overflow), 32'd1);
        do_clear();

        run_op(13'b0_1111_00000000, 1'b0);
        run_op(13'b0_0111_11000000, 1'b0);
`ifdef FP13_ACC_ROUND_EN
        check("t5_const", 32'(o_acumulado), 32'(13'b0_1111_00000010));
`else
        check("t5_const", 32'(o_acumulado), 32'(13'b0_1111_00000001));
`endif
        run_op(13'b0_0011_11001101, 1'b1);
        check("clrvalid_const", 32'(o_acumulado), 32'(13'b0_0011_11001101));

        // Reset while the operand sits in the ADD stage.
        @(negedge clock);
        i_valid = 1'b1; i_flotante = 13'b0_1010_01010101;
        @(negedge clock);
        i_valid = 1'b0;
        @(negedge clock);
        i_reset_n = 1'b0;
        #1;
        check("midrst_acc", 32'(o_acumulado), 32'd0);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_ovf", 32'(o_overflow), 32'd0);
        @(negedge clock);
        i_reset_n = 1'b1;
        model_acc = 13'd0; model_ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("midrst_no_pulse", 32'(o_valid), 32'd0);
        end
        check("midrst_acc_after", 32'(o_acumulado), 32'd0);
        $display("reset during ADD acc=%b", o_acumulado);

        for (int n = 0; n < 40; n++)
            run_op(13'($urandom), ($urandom_range(0, 7) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
